// File: rtl/m68k_ipl_sequencer_if.sv
// Interrupt request/acknowledge bundle between Paula's _ipl lines, the 68k core
// and the bus interface. The sequencer is the master side.
interface m68k_ipl_sequencer_if;
  logic [2:0] _ipl;
  logic [2:0] sr_mask;
  logic       boundary;
  logic       iack_ack;
  logic       iack_req;
  logic [2:0] iack_level;
  logic       exc_start;
  logic [7:0] exc_vector;
  logic [2:0] new_mask;
  logic       spurious;

  modport master (
    input  _ipl, sr_mask, boundary, iack_ack,
    output iack_req, iack_level, exc_start, exc_vector, new_mask, spurious
  );

  modport slave (
    output _ipl, sr_mask, boundary, iack_ack,
    input  iack_req, iack_level, exc_start, exc_vector, new_mask, spurious
  );
endinterface

// File: rtl/m68k_ipl_sequencer.sv
// CPU-side _ipl receiver: glitch filter, mask compare, NMI edge detect and the
// autovectored IACK handshake with spurious-vector timeout.
module m68k_ipl_sequencer #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [7:0]  AUTOVEC = 8'd24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk7_en,
  m68k_ipl_sequencer_if.master bus
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACK, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_raw_prev, r_flev, r_lvl, w_lvl_nxt;
  logic          r_nmi_edge, w_nmi_edge_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [7:0]    r_vec, w_vec_nxt;
  logic          r_spur, w_spur_nxt;
  logic [2:0]    w_raw, w_flev_nxt;
  logic          w_pending;

  assign w_raw      = ~bus._ipl;
  assign w_flev_nxt = (w_raw == r_raw_prev) ? w_raw : r_flev;
  assign w_pending  = ((r_flev == 3'd7) && r_nmi_edge) || (r_flev > bus.sr_mask);

  always_comb begin
    w_state_nxt    = r_state;
    w_lvl_nxt      = r_lvl;
    w_timer_nxt    = r_timer;
    w_vec_nxt      = r_vec;
    w_spur_nxt     = r_spur;
    w_nmi_edge_nxt = r_nmi_edge;
    case (r_state)
      IDLE: begin
        if (w_pending && bus.boundary) begin
          w_state_nxt = ACK;
          w_lvl_nxt   = r_flev;
          w_timer_nxt = '0;
          if (r_flev == 3'd7) w_nmi_edge_nxt = 1'b0;
        end
      end
      ACK: begin
        // ack is checked first so a coincident timeout still yields the autovector
        if (bus.iack_ack) begin
          w_state_nxt = DONE;
          w_vec_nxt   = AUTOVEC + {5'd0, r_lvl};
          w_spur_nxt  = 1'b0;
        end else if (r_timer == TLAST) begin
          w_state_nxt = DONE;
          w_vec_nxt   = AUTOVEC;
          w_spur_nxt  = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_timer_nxt = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
    if ((w_flev_nxt == 3'd7) && (r_flev != 3'd7)) w_nmi_edge_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_raw_prev <= '0;
      r_flev     <= '0;
      r_nmi_edge <= 1'b0;
      r_lvl      <= '0;
      r_timer    <= '0;
      r_vec      <= '0;
      r_spur     <= 1'b0;
    end else if (clk7_en) begin
      r_state    <= w_state_nxt;
      r_raw_prev <= w_raw;
      r_flev     <= w_flev_nxt;
      r_nmi_edge <= w_nmi_edge_nxt;
      r_lvl      <= w_lvl_nxt;
      r_timer    <= w_timer_nxt;
      r_vec      <= w_vec_nxt;
      r_spur     <= w_spur_nxt;
    end
  end

  assign bus.iack_req   = (r_state == ACK);
  assign bus.iack_level = (r_state == ACK)  ? r_lvl : '0;
  assign bus.exc_start  = (r_state == DONE);
  assign bus.exc_vector = (r_state == DONE) ? r_vec : '0;
  assign bus.new_mask   = (r_state == DONE) ? r_lvl : '0;
  assign bus.spurious   = (r_state == DONE) && r_spur;

endmodule

// File: tb/tb_m68k_ipl_sequencer.sv
// Directed scenarios plus randomized traffic, checked every tick against a
// behavioural model of the interrupt sequencer.
module tb_m68k_ipl_sequencer;
  localparam int TIMEOUT = 64;
  localparam int AUTOVEC = 24;

  logic clk = 1'b0;
  logic reset;
  logic clk7_en;
  int   checks = 0;
  int   errors = 0;

  m68k_ipl_sequencer_if bus();

  m68k_ipl_sequencer #(.TIMEOUT(64), .AUTOVEC(8'd24)) dut (
    .clk     (clk),
    .reset   (reset),
    .clk7_en (clk7_en),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // model state: last raw level, filtered level, pending NMI edge, handshake progress
  int m_last, m_flev, m_lvl, m_wait, m_vec;
  bit m_nmi, m_in_ack, m_pulse, m_spur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_finish(input int vec, input bit spur);
    m_in_ack = 0;
    m_pulse  = 1;
    m_vec    = vec;
    m_spur   = spur;
  endtask

  task automatic model_step();
    int  raw;
    int  newf;
    bit  pend;
    if (reset) begin
      m_last = 0; m_flev = 0; m_nmi = 0; m_in_ack = 0; m_pulse = 0;
      m_lvl = 0; m_wait = 0; m_vec = 0; m_spur = 0;
      return;
    end
    if (!clk7_en) return;
    raw  = 7 - int'(bus._ipl);
    pend = (m_flev == 7 && m_nmi) || (m_flev > int'(bus.sr_mask));
    if (m_pulse) begin
      m_pulse = 0;
    end else if (m_in_ack) begin
      if (bus.iack_ack)              model_finish(AUTOVEC + m_lvl, 0);
      else if (m_wait == TIMEOUT - 1) model_finish(AUTOVEC, 1);
      else                           m_wait++;
    end else if (pend && bus.boundary) begin
      m_in_ack = 1;
      m_lvl    = m_flev;
      m_wait   = 0;
      if (m_flev == 7) m_nmi = 0;
    end
    newf = (raw == m_last) ? raw : m_flev;
    if (newf == 7 && m_flev != 7) m_nmi = 1;
    m_flev = newf;
    m_last = raw;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("iack_req", 32'(bus.iack_req), 32'(m_in_ack));
    check("exc_start", 32'(bus.exc_start), 32'(m_pulse));
    if (m_in_ack) check("iack_level", 32'(bus.iack_level), 32'(m_lvl));
    if (m_pulse) begin
      check("exc_vector", 32'(bus.exc_vector), 32'(m_vec));
      check("new_mask", 32'(bus.new_mask), 32'(m_lvl));
      check("spurious", 32'(bus.spurious), 32'(m_spur));
    end else begin
      check("spurious_idle", 32'(bus.spurious), 32'd0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic settle();
    bus.iack_ack = 1'b0;
    bus.boundary = 1'b0;
    bus._ipl     = 3'b111;
    run(5);
  endtask

  task automatic wait_req(input string tag, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.iack_req && n < budget);
    check(tag, 32'(bus.iack_req), 32'd1);
  endtask

  initial begin
    int n, cnt, vec, ack_pct;

    reset = 1'b1; clk7_en = 1'b1;
    bus._ipl = 3'b111; bus.sr_mask = 3'd0; bus.boundary = 1'b0; bus.iack_ack = 1'b0;
    run(2);
    check("rst_iack_req", 32'(bus.iack_req), 32'd0);
    check("rst_iack_level", 32'(bus.iack_level), 32'd0);
    check("rst_exc_start", 32'(bus.exc_start), 32'd0);
    check("rst_exc_vector", 32'(bus.exc_vector), 32'd0);
    check("rst_new_mask", 32'(bus.new_mask), 32'd0);
    check("rst_spurious", 32'(bus.spurious), 32'd0);
    reset = 1'b0;
    run(2);

    // level 4 over mask 2, acked on the second ACK tick
    bus.sr_mask = 3'd2; bus.boundary = 1'b1; bus._ipl = 3'b011;
    wait_req("t1_req", 10, n);
    check("t1_latency", 32'(n), 32'd3);
    check("t1_level", 32'(bus.iack_level), 32'd4);
    tick();
    bus.iack_ack = 1'b1;
    bus.boundary = 1'b0;
    tick();
    check("t1_exc_start", 32'(bus.exc_start), 32'd1);
    check("t1_vector", 32'(bus.exc_vector), 32'd28);
    check("t1_mask", 32'(bus.new_mask), 32'd4);
    check("t1_spurious", 32'(bus.spurious), 32'd0);
    settle();

    // masked level, then unmasked
    bus.sr_mask = 3'd3; bus.boundary = 1'b1; bus._ipl = 3'b101;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.iack_req) cnt++;
    end
    check("t2_masked", 32'(cnt), 32'd0);
    bus.sr_mask = 3'd1;
    tick();
    check("t2_unmasked", 32'(bus.iack_req), 32'd1);
    bus.iack_ack = 1'b1;
    tick();
    settle();

    // single-tick glitch
    bus.sr_mask = 3'd0; bus.boundary = 1'b1;
    run(3);
    bus._ipl = 3'b000;
    tick();
    bus._ipl = 3'b111;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.iack_req) cnt++;
    end
    check("t3_glitch", 32'(cnt), 32'd0);
    settle();

    // NMI edge with mask 7: one exception per rising edge
    bus.sr_mask = 3'd7; bus.boundary = 1'b1; bus.iack_ack = 1'b1;
    for (int e = 0; e < 2; e++) begin
      bus._ipl = 3'b000;
      cnt = 0; vec = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (bus.exc_start) begin cnt++; vec = int'(bus.exc_vector); end
      end
      check("t4_nmi_count", 32'(cnt), 32'd1);
      check("t4_nmi_vector", 32'(vec), 32'd31);
      bus._ipl = 3'b111;
      run(5);
    end
    settle();

    // timeout -> spurious
    bus.sr_mask = 3'd2; bus.boundary = 1'b1; bus._ipl = 3'b100;
    wait_req("t5_req", 10, n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.exc_start && n < 100);
    check("t5_ticks", 32'(n), 32'd64);
    check("t5_vector", 32'(bus.exc_vector), 32'd24);
    check("t5_spurious", 32'(bus.spurious), 32'd1);
    check("t5_mask", 32'(bus.new_mask), 32'd3);
    settle();

    // clock-enable low freezes an outstanding request
    bus.sr_mask = 3'd0; bus.boundary = 1'b1; bus._ipl = 3'b110;
    wait_req("t7_req", 10, n);
    clk7_en = 1'b0;
    bus.iack_ack = 1'b1;
    run(10);
    check("t7_frozen_req", 32'(bus.iack_req), 32'd1);
    clk7_en = 1'b1;
    tick();
    check("t7_resume", 32'(bus.exc_start), 32'd1);
    settle();

    // reset in the middle of ACK
    bus.sr_mask = 3'd0; bus.boundary = 1'b1; bus._ipl = 3'b011;
    wait_req("t6_req", 10, n);
    run(3);
    reset = 1'b1;
    tick();
    check("t6_rst_req", 32'(bus.iack_req), 32'd0);
    check("t6_rst_exc", 32'(bus.exc_start), 32'd0);
    reset = 1'b0;
    bus.boundary = 1'b0; bus._ipl = 3'b111;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.exc_start) cnt++;
    end
    check("t6_no_exc", 32'(cnt), 32'd0);

    // ack on the same tick the timer expires
    bus.boundary = 1'b1; bus._ipl = 3'b011;
    wait_req("t6b_req", 10, n);
    run(TIMEOUT - 1);
    bus.iack_ack = 1'b1;
    tick();
    check("t6b_exc", 32'(bus.exc_start), 32'd1);
    check("t6b_vector", 32'(bus.exc_vector), 32'd28);
    check("t6b_spurious", 32'(bus.spurious), 32'd0);
    settle();

    // randomized traffic against the model
    for (int blk = 0; blk < 15; blk++) begin
      ack_pct = (blk % 3 == 0) ? 0 : int'($urandom_range(5, 40));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 9) == 0)  bus._ipl    = 3'($urandom);
        if ($urandom_range(0, 19) == 0) bus.sr_mask = 3'($urandom);
        bus.boundary = ($urandom_range(0, 99) < 70);
        bus.iack_ack = (int'($urandom_range(0, 99)) < ack_pct);
        clk7_en      = ($urandom_range(0, 99) < 80);
        reset        = ($urandom_range(0, 499) == 0);
        tick();
      end
    end
    reset = 1'b0; clk7_en = 1'b1;
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
